// File: rtl/disp_sched_if.sv
// Bundle between the display-source requesters and the scheduler: requests,
// per-channel BCD words, blink mask, and the scheduled word/ownership back.
interface disp_sched_if;
  logic [3:0]  req;
  logic [31:0] ch0_data;
  logic [31:0] ch1_data;
  logic [31:0] ch2_data;
  logic [31:0] ch3_data;
  logic [7:0]  blink_mask;
  logic [31:0] disp_data;
  logic [1:0]  owner;
  logic        owner_act;
  logic        switch_pulse;

  modport master (
    output req, ch0_data, ch1_data, ch2_data, ch3_data, blink_mask,
    input  disp_data, owner, owner_act, switch_pulse
  );

  modport slave (
    input  req, ch0_data, ch1_data, ch2_data, ch3_data, blink_mask,
    output disp_data, owner, owner_act, switch_pulse
  );
endinterface

// File: rtl/disp_sched.sv
// Display-source scheduler: urgent ch0 preempts, ch1..ch3 rotate round-robin with dwell,
// edit-field blinking and urgent flashing. DISP_SCHED_LZB_EN enables leading-zero blanking.
module disp_sched #(
  parameter int unsigned DWELL_CYC  = 100_000_000,
  parameter int unsigned BLINK_CYC  = 25_000_000,
  parameter logic [3:0]  BLANK_CODE = 4'hA
) (
  input  logic         clk,
  input  logic         rst_n,
  disp_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    URGENT = 2'd2
  } state_t;

  localparam int unsigned DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int unsigned BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
  localparam logic [31:0]   BLANK_WORD = {8{BLANK_CODE}};

  // Next requester after cur in order 1->2->3->1 (cur itself last); bit 2 = found.
  function automatic logic [2:0] rr_pick(input logic [1:0] cur, input logic [3:0] rq);
    logic [1:0] cand;
    logic [2:0] res;
    res  = 3'b000;
    cand = cur;
    for (int i = 0; i < 3; i++) begin
      cand = (cand == 2'd3) ? 2'd1 : (cand + 2'd1);
      res  = (!res[2] && rq[cand]) ? {1'b1, cand} : res;
    end
    return res;
  endfunction

  function automatic logic [31:0] lzb(input logic [31:0] d);
`ifdef DISP_SCHED_LZB_EN
    logic [31:0] r;
    logic        lead;
    r    = d;
    lead = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      lead         = lead & (d[4*k +: 4] == 4'h0);
      r[4*k +: 4]  = lead ? BLANK_CODE : d[4*k +: 4];
    end
    return r;
`else
    return d;
`endif
  endfunction

  function automatic logic [31:0] blink_apply(input logic [31:0] d, input logic [7:0] mask,
                                              input logic ph);
    logic [31:0] r;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = (ph && mask[k]) ? BLANK_CODE : d[4*k +: 4];
    end
    return r;
  endfunction

  state_t        state_r, state_s;
  logic [1:0]    owner_r, owner_s;
  logic          act_r, act_s;
  logic [1:0]    resume_r, resume_s;
  logic [DW-1:0] dwell_r, dwell_s;
  logic [BW-1:0] blink_cnt_r;
  logic          blink_ph_r;
  logic          urg_entry_s;
  logic [2:0]    pick_s;
  logic [3:0]    rq_s;
  logic          sw_s, sw_r;
  logic [31:0]   owner_data_s;
  logic [31:0]   disp_s, disp_r;

  // Next-state, owner and dwell selection; urgent preemption checked first.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    act_s       = act_r;
    resume_s    = resume_r;
    dwell_s     = dwell_r;
    urg_entry_s = 1'b0;
    pick_s      = 3'b000;
    rq_s        = {bus.req[3:1], 1'b0};
    if (bus.req[0] && (state_r != URGENT)) begin
      state_s     = URGENT;
      owner_s     = 2'd0;
      act_s       = 1'b1;
      dwell_s     = {DW{1'b0}};
      urg_entry_s = 1'b1;
      resume_s    = (state_r == SHOW) ? owner_r : resume_r;
    end else begin
      case (state_r)
        URGENT: begin
          pick_s  = rr_pick(resume_r, rq_s);
          dwell_s = {DW{1'b0}};
          if (bus.req[0]) begin
            state_s = URGENT;
          end else if (rq_s[resume_r]) begin
            state_s = SHOW;
            owner_s = resume_r;
          end else if (pick_s[2]) begin
            state_s = SHOW;
            owner_s = pick_s[1:0];
          end else begin
            state_s = IDLE;
            act_s   = 1'b0;
          end
        end
        IDLE: begin
          pick_s  = rr_pick(2'd0, rq_s);
          dwell_s = {DW{1'b0}};
          if (pick_s[2]) begin
            state_s = SHOW;
            owner_s = pick_s[1:0];
            act_s   = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        SHOW: begin
          pick_s = rr_pick(owner_r, rq_s);
          // Owner drop and dwell expiry collapse into one round-robin advance.
          if (!rq_s[owner_r] || (dwell_r == DWELL_LAST)) begin
            dwell_s = {DW{1'b0}};
            if (pick_s[2]) begin
              owner_s = pick_s[1:0];
            end else begin
              state_s = IDLE;
              act_s   = 1'b0;
            end
          end else begin
            dwell_s = dwell_r + DW'(1'b1);
          end
        end
        default: begin
          state_s = IDLE;
          act_s   = 1'b0;
          dwell_s = {DW{1'b0}};
        end
      endcase
    end
    sw_s = (owner_s != owner_r) || (act_s != act_r);
  end

  // Scheduler state, ownership and switch pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      owner_r  <= 2'd0;
      act_r    <= 1'b0;
      resume_r <= 2'd1;
      dwell_r  <= {DW{1'b0}};
      sw_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      owner_r  <= owner_s;
      act_r    <= act_s;
      resume_r <= resume_s;
      dwell_r  <= dwell_s;
      sw_r     <= sw_s;
    end
  end

  // Free-running blink phase, restarted on urgent entry so the flash begins visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_ph_r  <= 1'b0;
    end else if (urg_entry_s) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_ph_r  <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_ph_r  <= ~blink_ph_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1'b1);
    end
  end

  // Display word from the current state, live owner data, LZB and blink/flash.
  always_comb begin
    owner_data_s = 32'h0000_0000;
    disp_s       = BLANK_WORD;
    case (owner_r)
      2'd0:    owner_data_s = bus.ch0_data;
      2'd1:    owner_data_s = bus.ch1_data;
      2'd2:    owner_data_s = bus.ch2_data;
      2'd3:    owner_data_s = bus.ch3_data;
      default: owner_data_s = 32'h0000_0000;
    endcase
    case (state_r)
      IDLE:    disp_s = BLANK_WORD;
      SHOW:    disp_s = blink_apply(lzb(owner_data_s), bus.blink_mask, blink_ph_r);
      URGENT:  disp_s = blink_ph_r ? BLANK_WORD : lzb(bus.ch0_data);
      default: disp_s = BLANK_WORD;
    endcase
  end

  // Registered display word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_r <= BLANK_WORD;
    end else begin
      disp_r <= disp_s;
    end
  end

  assign bus.disp_data    = disp_r;
  assign bus.owner        = owner_r;
  assign bus.owner_act    = act_r;
  assign bus.switch_pulse = sw_r;

endmodule

// File: tb/tb_disp_sched.sv
// Scoreboard bench for disp_sched (DWELL_CYC=10, BLINK_CYC=4): expected owner switches are
// queued as stimulus is driven and popped on each switch_pulse; direct checks cover data paths.
module tb_disp_sched;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_cur = 3'b000;
  int   nb, np, no;

`ifdef DISP_SCHED_LZB_EN
  localparam logic [31:0] BLINK_ON  = 32'hAA1234AA;
  localparam logic [31:0] BLINK_OFF = 32'hAA123456;
`else
  localparam logic [31:0] BLINK_ON  = 32'h001234AA;
  localparam logic [31:0] BLINK_OFF = 32'h00123456;
`endif

  disp_sched_if bus ();

  disp_sched #(.DWELL_CYC(10), .BLINK_CYC(4), .BLANK_CODE(4'hA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Switch monitor: each pulse pops the next expected {owner_act,owner}; otherwise it must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_cur = 3'b000;
    end else if (bus.switch_pulse) begin
      if (exp_q.size() == 0) begin
        check("sw_unexpected", {29'd0, bus.owner_act, bus.owner}, 32'hFFFFFFFF);
      end else begin
        exp_cur = exp_q.pop_front();
        check("sw_owner", {29'd0, bus.owner_act, bus.owner}, {29'd0, exp_cur});
      end
    end else begin
      check("owner_hold", {29'd0, bus.owner_act, bus.owner}, {29'd0, exp_cur});
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus.req         = 4'b0000;
    bus.ch0_data    = 32'h0000_0000;
    bus.ch1_data    = 32'h11111111;
    bus.ch2_data    = 32'h22222222;
    bus.ch3_data    = 32'h33333333;
    bus.blink_mask  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_disp",  bus.disp_data, 32'hAAAAAAAA);
    check("rst_act",   {31'd0, bus.owner_act}, 32'd0);
    check("rst_owner", {30'd0, bus.owner}, 32'd0);
    check("rst_pulse", {31'd0, bus.switch_pulse}, 32'd0);

    // First grant one cycle after reset release.
    #1;
    exp_q.push_back(3'b101);
    bus.req = 4'b0010;
    rst_n   = 1'b1;
    @(negedge clk);
    check("grant_owner", {30'd0, bus.owner}, 32'd1);
    check("grant_act",   {31'd0, bus.owner_act}, 32'd1);
    check("grant_pulse", {31'd0, bus.switch_pulse}, 32'd1);
    check("grant_lat",   bus.disp_data, 32'hAAAAAAAA);

    // Round robin with dwell of 10 cycles.
    bus.req = 4'b1110;
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b111);
    exp_q.push_back(3'b101);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      check("rr_owner", {30'd0, bus.owner}, (i < 10) ? 32'd1 : (i < 20) ? 32'd2 : (i < 30) ? 32'd3 : 32'd1);
      if (i == 1) check("grant_data", bus.disp_data, 32'h11111111);
    end

    // Owner drop moves on in the same cycle.
    exp_q.push_back(3'b110);
    bus.req = 4'b1100;
    @(negedge clk);
    check("drop_owner", {30'd0, bus.owner}, 32'd2);

    // Urgent preemption and flashing.
    exp_q.push_back(3'b100);
    bus.req      = 4'b1111;
    bus.ch0_data = 32'h12345678;
    @(negedge clk);
    check("urg_owner", {30'd0, bus.owner}, 32'd0);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      check("urg_flash", bus.disp_data, (((j - 1) / 4) % 2 == 0) ? 32'h12345678 : 32'hAAAAAAAA);
    end

    // Resume to the preempted owner with dwell restarted.
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b111);
    bus.req = 4'b1110;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      check("resume_owner", {30'd0, bus.owner}, (k < 10) ? 32'd2 : 32'd3);
      if (k == 1) check("resume_data", bus.disp_data, 32'h22222222);
    end

    // Edit-field blinking on owner 1.
    exp_q.push_back(3'b101);
    bus.req        = 4'b0010;
    bus.ch1_data   = 32'h00123456;
    bus.blink_mask = 8'h03;
    @(negedge clk);
    check("blink_owner", {30'd0, bus.owner}, 32'd1);
    exp_q.push_back(3'b111);
    bus.req = 4'b1010;
    nb = 0; np = 0; no = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.disp_data === BLINK_ON) nb++;
      else if (bus.disp_data === BLINK_OFF) np++;
      else no++;
    end
    check("blink_on_cnt",  32'(nb), 32'd4);
    check("blink_off_cnt", 32'(np), 32'd4);
    check("blink_other",   32'(no), 32'd0);
    repeat (2) @(negedge clk);
    check("rr_to3_owner", {30'd0, bus.owner}, 32'd3);

    // Owner drop coinciding with dwell expiry: one advance, one pulse.
    repeat (9) @(negedge clk);
    check("dwell_hold", {30'd0, bus.owner}, 32'd3);
    exp_q.push_back(3'b101);
    bus.req = 4'b0010;
    @(negedge clk);
    check("coinc_owner", {30'd0, bus.owner}, 32'd1);
    check("coinc_pulse", {31'd0, bus.switch_pulse}, 32'd1);
    @(negedge clk);
    check("coinc_single", {31'd0, bus.switch_pulse}, 32'd0);
    check("sb_empty_mid", 32'(exp_q.size()), 32'd0);

    // Reset mid-SHOW is immediate.
    #1 rst_n = 1'b0;
    #1;
    check("mrst_disp",  bus.disp_data, 32'hAAAAAAAA);
    check("mrst_owner", {30'd0, bus.owner}, 32'd0);
    check("mrst_act",   {31'd0, bus.owner_act}, 32'd0);
    check("mrst_pulse", {31'd0, bus.switch_pulse}, 32'd0);
    @(negedge clk);
    #1;
    exp_q.push_back(3'b101);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_owner", {30'd0, bus.owner}, 32'd1);
    check("rel_act",   {31'd0, bus.owner_act}, 32'd1);
    @(negedge clk);
    check("sb_empty_end", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
